// File: rtl/fifo_stream_drain.sv
// Read-side drain for a synchronous FIFO: absorbs the one-cycle read latency in a
// 3-entry prefetch buffer and frames beats into packets. Define BEAT_CNT_EN for beat_count.
module fifo_stream_drain #(
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
`ifdef BEAT_CNT_EN
  ,
  output logic [CNT_W-1:0]  beat_count
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

  logic [DATA_W-1:0] buf_q [3];
  logic [DATA_W-1:0] buf_d [3];
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              push;
  logic              pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // The issue decision ignores a same-cycle pop so m_ready never reaches fifo_rd_en.
  assign fifo_rd_en = rst & ~fifo_empty & (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf_q[rd_ptr_q];
  assign m_last  = m_valid & (idx_q == LAST_IDX);

  always_comb begin
    push       = inflight_q;
    pop        = m_valid & m_ready;
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    idx_d      = idx_q;
    inflight_d = fifo_rd_en;

    if (push) begin
      buf_d[wr_ptr_q] = fifo_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
      idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + CNT_W'(1);
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      buf_q      <= buf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      idx_q      <= idx_d;
    end
  end

`ifdef BEAT_CNT_EN
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop) beat_cnt_d = beat_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) beat_cnt_q <= '0;
    else      beat_cnt_q <= beat_cnt_d;
  end

  assign beat_count = beat_cnt_q;
`endif

endmodule
